blur_filter: RTL and testbench

Streaming 3x3 Gaussian blur stage that sits directly upstream of `write_blur` in the augmentation path. On a `start` pulse it reads one source image from a BRAM read port in raster order and applies the [1 2 1; 2 4 2; 1 2 1]/16 kernel with zero padding at the image borders. It emits one blurred pixel per cycle on `pixel`/`pixel_valid`, which `write_blur` consumes unchanged.

---
 rtl/blur_pkg.sv | 26 ++
 rtl/blur_line_buffer.sv | 32 +++
 rtl/blur_filter.sv | 178 +++++++++++++++++
 tb/tb_blur_filter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/blur_pkg.sv
// rtl/blur_pkg.sv - shared constants, kernel weights and FSM state type for blur_filter
//
// Purpose: default geometry, 3x3 Gaussian kernel weights, accumulator width
//          and the frame-sequencing state enum used by blur_filter.
// Ports:   none (package).
package blur_pkg;

  localparam int DEF_WIDTH  = 28;
  localparam int DEF_HEIGHT = 28;
  localparam int DEF_ADDR_W = 11;

  // [1 2 1; 2 4 2; 1 2 1] / 16
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;

  // 16 * 255 = 4080 fits in 12 bits, with headroom for the +8 rounding term
  localparam int SUM_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/blur_line_buffer.sv
// rtl/blur_line_buffer.sv - DEPTH-deep 8-bit shift delay line for one image row
//
// Purpose: delays the sample stream by exactly DEPTH shifts.
// Ports:   clk     - clock
//          reset   - synchronous active-high reset, clears contents
//          i_en    - shift enable
//          i_data  - sample shifted in
//          o_data  - sample shifted in DEPTH enables ago
module blur_line_buffer #(
  parameter int DEPTH = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
    end else if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/blur_filter.sv
// rtl/blur_filter.sv - streaming 3x3 Gaussian blur with zero padding, BRAM source
//
// Purpose: on start, reads a WIDTH x HEIGHT image from BRAM in raster order and
//          emits one blurred pixel per cycle. Build option BLUR_ROUND_EN selects
//          round-half-up instead of truncation of sum/16.
// Ports:   clk, reset          - clock, synchronous active-high reset
//          start               - frame start request (accepted when idle)
//          busy, done          - frame in progress / one-cycle completion pulse
//          bram_addr, bram_en  - source read port (data one cycle later)
//          bram_data           - source pixel
//          pixel, pixel_valid  - blurred output stream
module blur_filter
  import blur_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [7:0]        bram_data,
  output logic [7:0]        pixel,
  output logic              pixel_valid
);

  localparam int N   = WIDTH * HEIGHT;
  localparam int J_W = ADDR_W + 1;  // sample index runs to N+WIDTH

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt;         // address in READ, flush cycle in FLUSH
  logic              r_shift;       // a sample is entering the window this cycle
  logic              r_is_data;     // that sample comes from BRAM (else zero)
  logic [J_W-1:0]    r_j;           // index of the sample entering this cycle
  logic [ADDR_W-1:0] r_row, r_col;  // position of the output being computed
  logic              r_busy, r_done, r_pixel_valid, r_pixel_last;
  logic [7:0]        r_pixel;
  // Registered window columns: [1] = centre column, [0] = left column
  logic [7:0]        r_win_t [2];
  logic [7:0]        r_win_m [2];
  logic [7:0]        r_win_b [2];

  logic [7:0]        w_sample, w_lb1, w_lb2, w_result;
  logic [7:0]        w_tap [3][3];
  logic [SUM_W-1:0]  w_sum;
  logic              w_accept, w_emit, w_last;
  logic              w_top_ok, w_bot_ok, w_left_ok, w_right_ok;

  assign w_accept = (r_state == IDLE) && start && !r_busy;
  assign w_sample = r_is_data ? bram_data : 8'd0;
  // The first complete window needs WIDTH+1 samples already behind it
  assign w_emit   = r_shift && (r_j > J_W'(WIDTH));
  assign w_last   = (r_row == ADDR_W'(HEIGHT-1)) && (r_col == ADDR_W'(WIDTH-1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = READ;
      READ:    if (r_cnt == ADDR_W'(N-1)) w_state_next = FLUSH;
      FLUSH:   if (r_cnt == ADDR_W'(WIDTH)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  blur_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk(clk), .reset(reset), .i_en(r_shift), .i_data(w_sample), .o_data(w_lb1)
  );
  blur_line_buffer #(.DEPTH(WIDTH)) u_lb2 (
    .clk(clk), .reset(reset), .i_en(r_shift), .i_data(w_lb1), .o_data(w_lb2)
  );

  // Buffers are never cleared between rows; stale or wrapped taps are masked
  // from the output position instead.
  assign w_top_ok   = (r_row != '0);
  assign w_bot_ok   = (r_row != ADDR_W'(HEIGHT-1));
  assign w_left_ok  = (r_col != '0);
  assign w_right_ok = (r_col != ADDR_W'(WIDTH-1));

  always_comb begin
    w_tap[0][0] = (w_top_ok && w_left_ok)  ? r_win_t[0] : 8'd0;
    w_tap[0][1] =  w_top_ok                ? r_win_t[1] : 8'd0;
    w_tap[0][2] = (w_top_ok && w_right_ok) ? w_lb2      : 8'd0;
    w_tap[1][0] =  w_left_ok               ? r_win_m[0] : 8'd0;
    w_tap[1][1] =  r_win_m[1];
    w_tap[1][2] =  w_right_ok              ? w_lb1      : 8'd0;
    w_tap[2][0] = (w_bot_ok && w_left_ok)  ? r_win_b[0] : 8'd0;
    w_tap[2][1] =  w_bot_ok                ? r_win_b[1] : 8'd0;
    w_tap[2][2] = (w_bot_ok && w_right_ok) ? w_sample   : 8'd0;
  end

  always_comb begin
    w_sum = SUM_W'(K_CORNER) * (SUM_W'(w_tap[0][0]) + SUM_W'(w_tap[0][2]) +
                                SUM_W'(w_tap[2][0]) + SUM_W'(w_tap[2][2]))
          + SUM_W'(K_EDGE)   * (SUM_W'(w_tap[0][1]) + SUM_W'(w_tap[1][0]) +
                                SUM_W'(w_tap[1][2]) + SUM_W'(w_tap[2][1]))
          + SUM_W'(K_CENTRE) *  SUM_W'(w_tap[1][1]);
  end

`ifdef BLUR_ROUND_EN
  assign w_result = 8'((w_sum + SUM_W'(8)) >> 4);
`else
  assign w_result = 8'(w_sum >> 4);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shift       <= 1'b0;
      r_is_data     <= 1'b0;
      r_j           <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pixel       <= 8'd0;
      r_pixel_valid <= 1'b0;
      r_pixel_last  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_win_t[i] <= 8'd0;
        r_win_m[i] <= 8'd0;
        r_win_b[i] <= 8'd0;
      end
    end else begin
      r_state <= w_state_next;
      if (r_state != w_state_next)  r_cnt <= '0;
      else if (r_state != IDLE)     r_cnt <= r_cnt + ADDR_W'(1);
      // BRAM data lags the address by one cycle, so the stream does too
      r_shift   <= (r_state != IDLE);
      r_is_data <= (r_state == READ);

      if (w_accept) begin
        r_j <= '0;
      end else if (r_shift) begin
        r_j        <= r_j + J_W'(1);
        r_win_t[0] <= r_win_t[1];
        r_win_m[0] <= r_win_m[1];
        r_win_b[0] <= r_win_b[1];
        r_win_t[1] <= w_lb2;
        r_win_m[1] <= w_lb1;
        r_win_b[1] <= w_sample;
      end

      if (w_accept) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_emit) begin
        if (r_col == ADDR_W'(WIDTH-1)) begin
          r_col <= '0;
          r_row <= r_row + ADDR_W'(1);
        end else begin
          r_col <= r_col + ADDR_W'(1);
        end
      end

      r_pixel_valid <= w_emit;
      r_pixel_last  <= w_emit && w_last;
      if (w_emit) r_pixel <= w_result;

      // busy spans the output pipeline drain, so a new start waits for done
      r_done <= r_pixel_last;
      if (w_accept)          r_busy <= 1'b1;
      else if (r_pixel_last) r_busy <= 1'b0;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign bram_en     = (r_state == READ);
  assign bram_addr   = (r_state == READ) ? r_cnt : '0;
  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_blur_filter.sv
// tb/tb_blur_filter.sv - directed table-driven bench for blur_filter (28x28)
module tb_blur_filter;

`ifdef BLUR_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, bram_en, pixel_valid;
  logic [10:0] bram_addr;
  logic [7:0]  bram_data = 8'd0;
  logic [7:0]  pixel;

  blur_filter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_data(bram_data),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) if (bram_en) bram_data <= mem[bram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int out_cnt, first_valid, done_cnt, done_cyc, first_busy, last_busy, s_cyc;
  logic [7:0] out_img [0:1023];

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (out_cnt < 1024) out_img[out_cnt] = pixel;
      if (first_valid < 0) first_valid = cyc;
      out_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) begin
      if (first_busy < 0) first_busy = cyc;
      last_busy = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
    case (pat)
      0: for (int i = 0; i < N; i++) mem[i] = 8'd255;
      1: mem[10*W+10] = 8'd16;
      2: mem[5*W+5] = 8'd8;
      default: for (int r = 0; r < H; r++) mem[r*W+27] = 8'd255;
    endcase
  endtask

  task automatic run_frame(input int glitch);
    out_cnt = 0; first_valid = -1; done_cnt = 0; done_cyc = -1;
    first_busy = -1; last_busy = -1;
    @(negedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 1000 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
      start = (glitch > 0) && (cyc == s_cyc + glitch);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
  endtask

  typedef struct {
    int pat;
    int row;
    int col;
    int exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{0, 0, 0, 143};
    vecs[1]  = '{0, 0, 5, 191};
    vecs[2]  = '{0, 5, 5, 255};
    vecs[3]  = '{0, 27, 27, 143};
    vecs[4]  = '{0, 27, 10, 191};
    vecs[5]  = '{0, 10, 0, 191};
    vecs[6]  = '{0, 10, 27, 191};
    vecs[7]  = '{0, 14, 14, 255};
    vecs[8]  = '{1, 10, 10, 4};
    vecs[9]  = '{1, 10, 11, 2};
    vecs[10] = '{1, 11, 11, 1};
    vecs[11] = '{1, 9, 9, 1};
    vecs[12] = '{1, 9, 10, 2};
    vecs[13] = '{1, 12, 10, 0};
    vecs[14] = '{1, 10, 12, 0};
    vecs[15] = '{1, 0, 0, 0};
    vecs[16] = '{2, 5, 5, 2};
    vecs[17] = '{2, 6, 6, ROUND ? 1 : 0};
    vecs[18] = '{2, 5, 6, 1};
    vecs[19] = '{2, 4, 4, ROUND ? 1 : 0};
    vecs[20] = '{3, 5, 27, ROUND ? 128 : 127};
    vecs[21] = '{3, 5, 26, ROUND ? 64 : 63};
    vecs[22] = '{3, 0, 27, ROUND ? 96 : 95};
    vecs[23] = '{3, 27, 26, ROUND ? 48 : 47};

    fill(0);
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset bram_en", int'(bram_en), 0);
    check("reset bram_addr", int'(bram_addr), 0);
    check("reset pixel", int'(pixel), 0);
    check("reset pixel_valid", int'(pixel_valid), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int p = 0; p < 4; p++) begin
      fill(p);
      run_frame(-1);
      check($sformatf("pat%0d out count", p), out_cnt, N);
      check($sformatf("pat%0d done count", p), done_cnt, 1);
      if (p == 0) begin
        check("first valid S+", first_valid - s_cyc, 32);
        check("done S+", done_cyc - s_cyc, 816);
        check("busy rise S+", first_busy - s_cyc, 1);
        check("busy fall S+", last_busy - s_cyc, 815);
      end
      for (int v = 0; v < NV; v++) begin
        if (vecs[v].pat == p)
          check($sformatf("pat%0d(%0d,%0d)", p, vecs[v].row, vecs[v].col),
                int'(out_img[vecs[v].row*W + vecs[v].col]), vecs[v].exp);
      end
      if (p == 3) begin
        for (int r = 0; r < H; r++)
          check($sformatf("colwrap(%0d,0)", r), int'(out_img[r*W]), 0);
      end
    end

    // start pulse during a frame must be ignored
    fill(1);
    run_frame(100);
    check("glitch out count", out_cnt, N);
    check("glitch done count", done_cnt, 1);
    check("glitch (10,10)", int'(out_img[10*W+10]), 4);
    check("glitch done S+", done_cyc - s_cyc, 816);

    // reset in the middle of a frame
    fill(0);
    @(negedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    while (cyc < s_cyc + 400) begin
      @(negedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); #1;
    check("midreset pixel_valid", int'(pixel_valid), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset bram_en", int'(bram_en), 0);
    check("midreset bram_addr", int'(bram_addr), 0);
    check("midreset pixel", int'(pixel), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    fill(1);
    run_frame(-1);
    check("postreset out count", out_cnt, N);
    check("postreset done count", done_cnt, 1);
    check("postreset first valid S+", first_valid - s_cyc, 32);
    check("postreset (10,10)", int'(out_img[10*W+10]), 4);
    check("postreset (9,9)", int'(out_img[9*W+9]), 1);
    check("postreset (0,0)", int'(out_img[0]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
